// File: rtl/input_vc_controller_pkg.sv
// Shared router constants, flit-type encodings and input-VC state encoding.
// Flit layout: [DW-1:DW-2] vcid, [DW-3:DW-4] type, remaining bits payload.
package input_vc_controller_pkg;

    localparam int DW            = 16;
    localparam int V             = 4;
    localparam int P             = 5;
    localparam int P_LOG         = 3;
    localparam int BUF_DEPTH     = 4;
    localparam int BUF_DEPTH_LOG = 2;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ROUTING,
        S_VC_ALLOC,
        S_ACTIVE
    } vc_state_e;

    function automatic logic starts_packet(input logic [1:0] flit_type);
        return (flit_type == HEAD) || (flit_type == HEADTAIL);
    endfunction

    function automatic logic ends_packet(input logic [1:0] flit_type);
        return (flit_type == TAIL) || (flit_type == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_flit_fifo.sv
// Flit buffer for one input VC: array storage with an asynchronous head read so a
// written flit is visible at the head on the next cycle.
module vc_flit_fifo #(
    parameter int WIDTH     = 14,
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int CNT_W = DEPTH_LOG + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_reg;
    logic [DEPTH_LOG-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [DEPTH_LOG-1:0] wrap_inc(input logic [DEPTH_LOG-1:0] ptr);
        return (ptr == DEPTH_LOG'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign do_push   = push & (~full | do_pop);
    assign overflow  = push & full & ~do_pop;
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wrap_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= wrap_inc(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_vc_controller.sv
// Input virtual-channel controller: buffers flits of one VC and walks each packet
// through route computation, VC allocation and switch traversal, returning credits.
module input_vc_controller
    import input_vc_controller_pkg::*;
#(
    parameter logic [1:0] VCID = 2'd0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inValid,
    input  logic [DW-1:0]    inDat,
    output logic             routeReq,
    input  logic             routeDone,
    input  logic [P_LOG-1:0] routePort,
    output logic             vaReq,
    input  logic             vaGrant,
    input  logic [1:0]       vaOutVC,
    input  logic             outVCReady,
    output logic             saReq,
    input  logic             saGrant,
    output logic             outValid,
    output logic [DW-1:0]    outDat,
    output logic [P_LOG-1:0] outPort,
    output logic             creditUpdate,
    output logic             errFlag
);

    localparam int CNT_W = BUF_DEPTH_LOG + 1;

    vc_state_e        state_reg, state_next;
    logic [CNT_W-1:0] init_cnt_reg, init_cnt_next;
    logic [P_LOG-1:0] out_port_reg, out_port_next;
    logic [1:0]       out_vc_reg, out_vc_next;
    logic             err_reg, err_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic [DW-3:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;
    logic [1:0]       head_type;
    logic             proto_err;

    // The vcid field is implied by the buffer itself, so only type and payload are stored.
    assign fifo_push = inValid && (inDat[DW-1:DW-2] == VCID);
    assign head_type = fifo_head[DW-3:DW-4];

    vc_flit_fifo #(
        .WIDTH     (DW - 2),
        .DEPTH     (BUF_DEPTH),
        .DEPTH_LOG (BUF_DEPTH_LOG)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (inDat[DW-3:0]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        out_port_next = out_port_reg;
        out_vc_next   = out_vc_reg;
        routeReq      = 1'b0;
        vaReq         = 1'b0;
        saReq         = 1'b0;
        outValid      = 1'b0;
        outDat        = '0;
        creditUpdate  = 1'b0;
        fifo_pop      = 1'b0;
        proto_err     = 1'b0;

        case (state_reg)
            S_INIT: begin
                // Count 0 is the idle cycle right after reset; counts 1..BUF_DEPTH each carry a credit.
                creditUpdate = (init_cnt_reg != '0);
                if (init_cnt_reg == CNT_W'(BUF_DEPTH)) begin
                    init_cnt_next = '0;
                    state_next    = S_IDLE;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (starts_packet(head_type)) begin
                        state_next = S_ROUTING;
                    end else begin
                        fifo_pop     = 1'b1;
                        creditUpdate = 1'b1;
                        proto_err    = 1'b1;
                    end
                end
            end
            S_ROUTING: begin
                routeReq = 1'b1;
                if (routeDone) begin
                    out_port_next = routePort;
                    state_next    = S_VC_ALLOC;
                end
            end
            S_VC_ALLOC: begin
                vaReq = 1'b1;
                if (vaGrant) begin
                    out_vc_next = vaOutVC;
                    state_next  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                saReq = !fifo_empty && outVCReady;
                if (saReq && saGrant) begin
                    outValid     = 1'b1;
                    outDat       = {out_vc_reg, fifo_head};
                    fifo_pop     = 1'b1;
                    creditUpdate = 1'b1;
                    if (ends_packet(head_type)) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next    = S_INIT;
                init_cnt_next = '0;
            end
        endcase

        err_next = err_reg | proto_err | fifo_overflow;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_INIT;
            init_cnt_reg <= '0;
            out_port_reg <= '0;
            out_vc_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            out_port_reg <= out_port_next;
            out_vc_reg   <= out_vc_next;
            err_reg      <= err_next;
        end
    end

    assign outPort = out_port_reg;
    assign errFlag = err_reg;

endmodule

// File: tb/tb_input_vc_controller.sv
// Directed bench for input_vc_controller (VCID=1): expected crossbar flits are queued
// as flits are injected and checked as each outValid beat appears.
module tb_input_vc_controller;
    import input_vc_controller_pkg::*;

    logic             clk = 1'b0;
    logic             rstn;
    logic             inValid;
    logic [DW-1:0]    inDat;
    logic             routeReq;
    logic             routeDone;
    logic [P_LOG-1:0] routePort;
    logic             vaReq;
    logic             vaGrant;
    logic [1:0]       vaOutVC;
    logic             outVCReady;
    logic             saReq;
    logic             saGrant;
    logic             outValid;
    logic [DW-1:0]    outDat;
    logic [P_LOG-1:0] outPort;
    logic             creditUpdate;
    logic             errFlag;

    typedef struct {
        logic [DW-1:0]    dat;
        logic [P_LOG-1:0] port;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   beats      = 0;
    int   pulses;

    always #5 clk = ~clk;

    input_vc_controller #(.VCID(2'd1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .inValid      (inValid),
        .inDat        (inDat),
        .routeReq     (routeReq),
        .routeDone    (routeDone),
        .routePort    (routePort),
        .vaReq        (vaReq),
        .vaGrant      (vaGrant),
        .vaOutVC      (vaOutVC),
        .outVCReady   (outVCReady),
        .saReq        (saReq),
        .saGrant      (saGrant),
        .outValid     (outValid),
        .outDat       (outDat),
        .outPort      (outPort),
        .creditUpdate (creditUpdate),
        .errFlag      (errFlag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then score any crossbar beat.
    task automatic look();
        exp_t e;
        #1;
        if (outValid === 1'b1) begin
            beats++;
            $display("beat %0d: outDat=%h outPort=%0d credit=%0b", beats, outDat, outPort, creditUpdate);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("out_dat", 32'(outDat), 32'(e.dat));
                chk("out_port", 32'(outPort), 32'(e.port));
            end
        end
    endtask

    // Drive a link flit; matching-VC flits also queue their expected crossbar image.
    task automatic send(input logic [1:0] vc, input logic [1:0] ftype, input logic [11:0] payload,
                        input bit expect_out);
        exp_t e;
        inValid = 1'b1;
        inDat   = {vc, ftype, payload};
        if (expect_out) begin
            e.dat  = {2'd3, ftype, payload};
            e.port = 3'd2;
            sb.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        inValid    = 1'b0;
        inDat      = '0;
        routeDone  = 1'b0;
        routePort  = '0;
        vaGrant    = 1'b0;
        vaOutVC    = '0;
        outVCReady = 1'b0;
        saGrant    = 1'b0;
    endtask

    task automatic quick_reset();
        rstn = 1'b0;
        idle_inputs();
        sb.delete();
        beats = 0;
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        look();
        chk("reinit_idle", 32'(dut.state_reg), 32'(S_IDLE));
        chk("reinit_err", 32'(errFlag), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        look();
        chk("rst_credit", 32'(creditUpdate), 32'd0);
        chk("rst_state", 32'(dut.state_reg), 32'(S_INIT));
        chk("rst_err", 32'(errFlag), 32'd0);
        chk("rst_outport", 32'(outPort), 32'd0);
        chk("rst_reqs", 32'({routeReq, vaReq, saReq, outValid}), 32'd0);
        chk("rst_count", 32'(dut.u_fifo.count_reg), 32'd0);

        // Credit burst after release.
        rstn = 1'b1;
        look();
        chk("init_cycle0_credit", 32'(creditUpdate), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            look();
            chk("init_credit", 32'(creditUpdate), 32'd1);
        end
        tick();
        look();
        chk("init_credit_off", 32'(creditUpdate), 32'd0);
        chk("init_idle", 32'(dut.state_reg), 32'(S_IDLE));

        // Flits for another VC are ignored.
        send(2'd2, HEAD, 12'h111, 1'b0);
        tick();
        inValid = 1'b0;
        look();
        chk("vcid_filter_count", 32'(dut.u_fifo.count_reg), 32'd0);

        // Three-flit packet through route, VC and switch allocation.
        send(2'd1, HEAD, 12'h0A1, 1'b1);
        tick();
        send(2'd1, BODY, 12'h0B2, 1'b1);
        look();
        chk("pkt_head_visible", 32'(dut.u_fifo.count_reg), 32'd1);
        chk("pkt_still_idle", 32'(dut.state_reg), 32'(S_IDLE));
        tick();
        send(2'd1, TAIL, 12'h0C3, 1'b1);
        look();
        chk("pkt_routing", 32'(dut.state_reg), 32'(S_ROUTING));
        chk("pkt_routereq", 32'(routeReq), 32'd1);
        tick();
        inValid   = 1'b0;
        routeDone = 1'b1;
        routePort = 3'd2;
        look();
        chk("pkt_routereq_hold", 32'(routeReq), 32'd1);
        chk("pkt_count3", 32'(dut.u_fifo.count_reg), 32'd3);
        tick();
        routeDone = 1'b0;
        routePort = 3'd0;
        vaGrant   = 1'b1;
        vaOutVC   = 2'd3;
        look();
        chk("pkt_vareq", 32'(vaReq), 32'd1);
        chk("pkt_routereq_off", 32'(routeReq), 32'd0);
        chk("pkt_outport", 32'(outPort), 32'd2);
        tick();
        vaGrant    = 1'b0;
        vaOutVC    = 2'd0;
        outVCReady = 1'b1;
        saGrant    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("pkt_sareq", 32'(saReq), 32'd1);
            chk("pkt_valid", 32'(outValid), 32'd1);
            chk("pkt_credit", 32'(creditUpdate), 32'd1);
            tick();
        end
        look();
        chk("pkt_back_idle", 32'(dut.state_reg), 32'(S_IDLE));
        chk("pkt_valid_off", 32'(outValid), 32'd0);
        chk("pkt_sareq_off", 32'(saReq), 32'd0);
        chk("pkt_beats", 32'(beats), 32'd3);
        chk("pkt_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow while waiting for a route.
        quick_reset();
        send(2'd1, HEAD, 12'h1A0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            send(2'd1, BODY, 12'(12'h1B0 + i), 1'b0);
            tick();
        end
        send(2'd1, TAIL, 12'h1C0, 1'b0);
        look();
        chk("ovf_full_count", 32'(dut.u_fifo.count_reg), 32'd4);
        chk("ovf_err_before", 32'(errFlag), 32'd0);
        chk("ovf_routing", 32'(dut.state_reg), 32'(S_ROUTING));
        tick();
        inValid = 1'b0;
        look();
        chk("ovf_err", 32'(errFlag), 32'd1);
        chk("ovf_count_held", 32'(dut.u_fifo.count_reg), 32'd4);

        // Full buffer: write and pop together, then stall on outVCReady, then drain.
        quick_reset();
        send(2'd1, HEAD, 12'h2A0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            send(2'd1, BODY, 12'(12'h2B0 + i), 1'b1);
            tick();
        end
        inValid   = 1'b0;
        routeDone = 1'b1;
        routePort = 3'd2;
        tick();
        routeDone = 1'b0;
        vaGrant   = 1'b1;
        vaOutVC   = 2'd3;
        tick();
        vaGrant = 1'b0;
        look();
        chk("full_active", 32'(dut.state_reg), 32'(S_ACTIVE));
        chk("full_count", 32'(dut.u_fifo.count_reg), 32'd4);
        send(2'd1, TAIL, 12'h2C0, 1'b1);
        outVCReady = 1'b1;
        saGrant    = 1'b1;
        look();
        chk("full_rw_valid", 32'(outValid), 32'd1);
        tick();
        inValid = 1'b0;
        saGrant = 1'b0;
        look();
        chk("full_rw_count", 32'(dut.u_fifo.count_reg), 32'd4);
        chk("full_rw_err", 32'(errFlag), 32'd0);
        outVCReady = 1'b0;
        saGrant    = 1'b1;
        look();
        chk("stall_sareq", 32'(saReq), 32'd0);
        chk("stall_valid", 32'(outValid), 32'd0);
        chk("stall_credit", 32'(creditUpdate), 32'd0);
        tick();
        look();
        chk("stall_count", 32'(dut.u_fifo.count_reg), 32'd4);
        outVCReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look();
            tick();
        end
        saGrant    = 1'b0;
        outVCReady = 1'b0;
        look();
        chk("drain_idle", 32'(dut.state_reg), 32'(S_IDLE));
        chk("drain_beats", 32'(beats), 32'd5);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_count", 32'(dut.u_fifo.count_reg), 32'd0);

        // Packet starting with a BODY flit.
        send(2'd1, BODY, 12'h0EE, 1'b0);
        tick();
        inValid = 1'b0;
        look();
        chk("body_first_credit", 32'(creditUpdate), 32'd1);
        chk("body_first_err_pre", 32'(errFlag), 32'd0);
        tick();
        look();
        chk("body_first_err", 32'(errFlag), 32'd1);
        chk("body_first_count", 32'(dut.u_fifo.count_reg), 32'd0);
        chk("body_first_idle", 32'(dut.state_reg), 32'(S_IDLE));
        chk("body_first_credit_off", 32'(creditUpdate), 32'd0);

        // Reset mid-packet flushes the buffer and re-issues all credits.
        quick_reset();
        send(2'd1, HEAD, 12'h3A0, 1'b0);
        tick();
        send(2'd1, BODY, 12'h3B0, 1'b0);
        tick();
        inValid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_count", 32'(dut.u_fifo.count_reg), 32'd0);
        chk("midrst_state", 32'(dut.state_reg), 32'(S_INIT));
        chk("midrst_outs", 32'({routeReq, creditUpdate}), 32'd0);
        tick();
        rstn   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            look();
            if (creditUpdate === 1'b1) pulses++;
            tick();
        end
        chk("midrst_credits", 32'(pulses), 32'd4);
        chk("midrst_idle", 32'(dut.state_reg), 32'(S_IDLE));
        chk("midrst_empty", 32'(dut.u_fifo.count_reg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
